vert_timing_gen: RTL and testbench
==================================

// Module: vert_timing_gen
// PURPOSE
//   Parametrised vertical timing generator for the VGA driver. Counts lines on a
//   per-line enable from the horizontal counter. Decodes the frame into four phases:
//   active, front porch, sync and back porch. Drives VSYNC, the vertical-active
//   flag and frame markers to the pixel/sync output stage. Also supports a
//   synchronous frame resync.
// PARAMETERS
//   W        10   width of line counter CNT; must satisfy 2**W >= TOTAL
//   V_VIS    600  visible lines
//   V_FP     37   front-porch lines
//   V_SYNC   6    sync-pulse lines
//   V_BP     23   back-porch lines
//   SYNC_POL 1    VSYNC level during sync phase (1 = active-high, 0 = active-low)
//   (derived) TOTAL = V_VIS+V_FP+V_SYNC+V_BP = 666 default; each phase length >= 1
// PORTS
//   CLK          in   1  pixel clock; all state changes on rising edge
//   RST          in   1  synchronous reset, active-high
//   CE           in   1  line-advance enable, 1-cycle pulse at end of each line
//   RESYNC       in   1  synchronous request to restart frame at line 0
//   CNT          out  W  current line index, 0..TOTAL-1
//   PHASE        out  2  0=ACTIVE 1=FRONT 2=SYNC 3=BACK
//   VACTIVE      out  1  1 while PHASE==ACTIVE (CNT < V_VIS)
//   VSYNC        out  1  SYNC_POL in SYNC phase, ~SYNC_POL otherwise
//   LAST_LINE    out  1  1 while CNT == TOTAL-1
//   FRAME_START  out  1  1-cycle pulse in the cycle CNT becomes 0 by wrap or RESYNC
// BEHAVIOUR
//   - All outputs are registered and update on the same edge as CNT. Decode is
//     from the next count value, so outputs always match CNT with zero skew.
//   - Reset (RST=1 at edge): CNT=0, PHASE=ACTIVE, VACTIVE=1, VSYNC=~SYNC_POL,
//     LAST_LINE=0, FRAME_START=0. RST overrides CE and RESYNC. It takes effect
//     mid-frame with no completion of the current phase.
//   - Priority per edge: RST > RESYNC > CE > hold.
//   - CE=1: if CNT==TOTAL-1 then CNT<=0 and FRAME_START<=1, else CNT<=CNT+1.
//     Never exceeds TOTAL-1.
//   - RESYNC=1: CNT<=0, PHASE<=ACTIVE, FRAME_START<=1, regardless of CE or current
//     count. RESYNC while already at CNT==0 still pulses FRAME_START.
//   - CE=0 and RESYNC=0: CNT, PHASE and level outputs hold; FRAME_START<=0.
//   - FRAME_START is never high two consecutive cycles unless RESYNC or a wrap
//     occurs on each of them.
//   - Phase FSM, advanced only on CE:
//       ACTIVE -> FRONT at CNT V_VIS-1 -> V_VIS
//       FRONT  -> SYNC  at V_VIS+V_FP-1
//       SYNC   -> BACK  at V_VIS+V_FP+V_SYNC-1
//       BACK   -> ACTIVE on wrap TOTAL-1 -> 0
//   - PHASE always equals the range decode of CNT; no illegal encodings.
//   - Counter arithmetic is unsigned W-bit. Comparisons use constants computed from
//     the parameters at elaboration. An illegal parameter set (any phase 0, or
//     2**W < TOTAL) is a $error at elaboration.
// TESTING
//   1. RST 3 cycles, then CE every 4th cycle for 2*666 lines ->
//      CNT runs 0..665 and wraps; FRAME_START pulses exactly twice.
//   2. Defaults, step to CNT 599 -> 600: VACTIVE 1->0, PHASE 0->1.
//      At 636 -> 637: VSYNC 0->1, PHASE 2. At 643: VSYNC 1->0, PHASE 3.
//   3. SYNC_POL=0, V_VIS=4 V_FP=1 V_SYNC=2 V_BP=1 -> VSYNC low only at CNT 5,6;
//      LAST_LINE only at 7; wrap to 0 with FRAME_START.
//   4. At CNT=300, assert RESYNC and CE together -> next CNT=0, PHASE=0,
//      FRAME_START=1 for one cycle.
//   5. At CNT=640 (SYNC phase), RST=1 with CE=1 -> CNT=0, VSYNC=~SYNC_POL,
//      FRAME_START=0.
//   6. CE held 0 for 100 cycles at CNT=665 -> all outputs stable, LAST_LINE=1.
//      The first CE wraps to 0.

Source files
------------

// File: rtl/vert_timing_gen_if.sv
// rtl/vert_timing_gen_if.sv - line-advance controls and decoded vertical timing outputs
//
// Purpose: groups the vertical timing generator's control inputs and decoded
// outputs into one bundle shared by the line-enable source and the sync stage.
// Signals:
//   ce          line-advance enable, 1-cycle pulse at end of each line
//   resync      request to restart the frame at line 0
//   cnt         current line index, 0..TOTAL-1
//   phase       0=ACTIVE 1=FRONT 2=SYNC 3=BACK
//   vactive     high while in the active phase
//   vsync       sync level during SYNC phase, idle level otherwise
//   last_line   high while cnt is the final line of the frame
//   frame_start 1-cycle pulse when cnt becomes 0 by wrap or resync
// Modports: master drives ce/resync and observes timing; slave is the generator.
interface vert_timing_gen_if #(
  parameter int W = 10
) ();
  logic         ce;
  logic         resync;
  logic [W-1:0] cnt;
  logic [1:0]   phase;
  logic         vactive;
  logic         vsync;
  logic         last_line;
  logic         frame_start;

  modport master (
    output ce, resync,
    input  cnt, phase, vactive, vsync, last_line, frame_start
  );

  modport slave (
    input  ce, resync,
    output cnt, phase, vactive, vsync, last_line, frame_start
  );
endinterface

// File: rtl/vert_timing_gen.sv
// rtl/vert_timing_gen.sv - parametrised vertical timing generator for the VGA driver
//
// Purpose: counts lines on the per-line enable, tracks the frame phase
// (active, front porch, sync, back porch) and drives registered VSYNC,
// vertical-active, last-line and frame-start markers.
// Ports:
//   clk  in  pixel clock, all state changes on the rising edge
//   rst  in  synchronous reset, active-high; overrides resync and ce
//   bus  slave modport of vert_timing_gen_if (ce, resync in; timing out)
// Every output is updated on the same edge as cnt from the next-state
// decision, so outputs never lag the count.
module vert_timing_gen #(
  parameter int W        = 10,
  parameter int V_VIS    = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  vert_timing_gen_if.slave      bus
);

  localparam int TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Count values on which a CE moves into the following phase.
  localparam logic [W-1:0] C_ACT_END  = W'(V_VIS - 1);
  localparam logic [W-1:0] C_FP_END   = W'(V_VIS + V_FP - 1);
  localparam logic [W-1:0] C_SYNC_END = W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [W-1:0] C_LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] C_PRELAST  = W'(TOTAL - 2);
  localparam logic [W-1:0] C_ONE      = W'(1);
  localparam logic         IDLE_LVL   = ~SYNC_POL;

  generate
    if (V_VIS < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || (2 ** W) < TOTAL) begin : g_bad_params
      $error("vert_timing_gen: illegal parameter set (empty phase or W too small)");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } phase_t;

  phase_t       state;
  logic [W-1:0] cnt;
  logic         vactive;
  logic         vsync;
  logic         last_line;
  logic         frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      state       <= ST_ACTIVE;
      vactive     <= 1'b1;
      vsync       <= IDLE_LVL;
      last_line   <= 1'b0;
      frame_start <= 1'b0;
    end else if (bus.resync || (bus.ce && cnt == C_LAST)) begin
      // Resync and natural wrap both land on line 0 of a fresh frame.
      cnt         <= '0;
      state       <= ST_ACTIVE;
      vactive     <= 1'b1;
      vsync       <= IDLE_LVL;
      last_line   <= 1'b0;
      frame_start <= 1'b1;
    end else if (bus.ce) begin
      cnt         <= cnt + C_ONE;
      last_line   <= (cnt == C_PRELAST);
      frame_start <= 1'b0;
      case (state)
        ST_ACTIVE: begin
          if (cnt == C_ACT_END) begin
            state   <= ST_FRONT;
            vactive <= 1'b0;
          end
        end
        ST_FRONT: begin
          if (cnt == C_FP_END) begin
            state <= ST_SYNC;
            vsync <= SYNC_POL;
          end
        end
        ST_SYNC: begin
          if (cnt == C_SYNC_END) begin
            state <= ST_BACK;
            vsync <= IDLE_LVL;
          end
        end
        ST_BACK: begin
          // Leaves only through the wrap branch above.
          state <= ST_BACK;
        end
      endcase
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign bus.cnt         = cnt;
  assign bus.phase       = state;
  assign bus.vactive     = vactive;
  assign bus.vsync       = vsync;
  assign bus.last_line   = last_line;
  assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_vert_timing_gen.sv
// tb/tb_vert_timing_gen.sv - directed bench for vert_timing_gen (default and tiny frame)
module tb_vert_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   exp_a = 0;
  int   fs_seen = 0;

  always #5 clk = ~clk;

  vert_timing_gen_if #(.W(10)) a ();
  vert_timing_gen_if #(.W(3))  b ();

  vert_timing_gen #(
    .W(10), .V_VIS(600), .V_FP(37), .V_SYNC(6), .V_BP(23), .SYNC_POL(1'b1)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(a.slave)
  );

  vert_timing_gen #(
    .W(3), .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(b.slave)
  );

  typedef struct {
    logic ce;
    logic rs;
    logic rst;
    int   cnt;
    int   ph;
    int   va;
    int   vs;
    int   ll;
    int   fs;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Default frame: expected decode of a line index from the phase boundaries.
  task automatic chk_a(input int c, input int fs);
    int ph;
    ph = (c < 600) ? 0 : (c < 637) ? 1 : (c < 643) ? 2 : 3;
    chk("a_cnt", int'(a.cnt), c);
    chk("a_phase", int'(a.phase), ph);
    chk("a_vactive", int'(a.vactive), (c < 600) ? 1 : 0);
    chk("a_vsync", int'(a.vsync), (ph == 2) ? 1 : 0);
    chk("a_last_line", int'(a.last_line), (c == 665) ? 1 : 0);
    chk("a_frame_start", int'(a.frame_start), fs);
  endtask

  task automatic step_a(input logic ce, input logic rs, input logic r);
    int fs;
    a.ce = ce;
    a.resync = rs;
    rst = r;
    tick();
    fs = 0;
    if (r) exp_a = 0;
    else if (rs) begin exp_a = 0; fs = 1; end
    else if (ce) begin
      if (exp_a == 665) begin exp_a = 0; fs = 1; end
      else exp_a = exp_a + 1;
    end
    if (a.frame_start) fs_seen++;
    chk_a(exp_a, fs);
    a.ce = 1'b0;
    a.resync = 1'b0;
    rst = 1'b0;
  endtask

  task automatic adv_a_to(input int target);
    while (exp_a != target) step_a(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    a.ce = 1'b0; a.resync = 1'b0;
    b.ce = 1'b0; b.resync = 1'b0;

    // Tiny frame: lines 0-3 active, 4 front, 5-6 sync (vsync low), 7 back.
    //            ce    rs    rst   cnt ph va vs ll fs
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 0, 0, 1, 1, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1, 1, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2, 0, 1, 1, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3, 0, 1, 1, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4, 1, 0, 1, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 4, 1, 0, 1, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 5, 2, 0, 0, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 6, 2, 0, 0, 0, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 7, 3, 0, 1, 1, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 7, 3, 0, 1, 1, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 0, 0, 1, 1, 0, 1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 1, 0, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 1, 0, 1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 1, 0, 1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1, 0, 1, 1, 0, 0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 0, 0, 1, 1, 0, 1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1, 0, 1, 1, 0, 0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 2, 0, 1, 1, 0, 0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 3, 0, 1, 1, 0, 0};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 0, 0, 1, 1, 0, 0};

    for (int i = 0; i < 20; i++) begin
      b.ce = tbl[i].ce;
      b.resync = tbl[i].rs;
      rst = tbl[i].rst;
      tick();
      chk($sformatf("b_cnt[%0d]", i), int'(b.cnt), tbl[i].cnt);
      chk($sformatf("b_phase[%0d]", i), int'(b.phase), tbl[i].ph);
      chk($sformatf("b_vactive[%0d]", i), int'(b.vactive), tbl[i].va);
      chk($sformatf("b_vsync[%0d]", i), int'(b.vsync), tbl[i].vs);
      chk($sformatf("b_last_line[%0d]", i), int'(b.last_line), tbl[i].ll);
      chk($sformatf("b_frame_start[%0d]", i), int'(b.frame_start), tbl[i].fs);
    end
    b.ce = 1'b0; b.resync = 1'b0; rst = 1'b0;

    // Reset held three cycles, then CE every 4th cycle for two full frames.
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, 1'b1);
    fs_seen = 0;
    for (int i = 0; i < 2 * 666 * 4; i++) step_a((i % 4) == 3, 1'b0, 1'b0);
    chk("a_two_frame_pulses", fs_seen, 2);

    // Phase boundaries of the default frame.
    adv_a_to(599);
    chk("a_599_vactive", int'(a.vactive), 1);
    step_a(1'b1, 1'b0, 1'b0);
    chk("a_600_vactive", int'(a.vactive), 0);
    chk("a_600_phase", int'(a.phase), 1);
    adv_a_to(637);
    chk("a_637_vsync", int'(a.vsync), 1);
    chk("a_637_phase", int'(a.phase), 2);
    adv_a_to(643);
    chk("a_643_vsync", int'(a.vsync), 0);
    chk("a_643_phase", int'(a.phase), 3);

    // Resync together with CE mid-frame.
    step_a(1'b0, 1'b1, 1'b0);
    adv_a_to(300);
    step_a(1'b1, 1'b1, 1'b0);
    chk("a_resync_cnt", int'(a.cnt), 0);
    chk("a_resync_fs", int'(a.frame_start), 1);
    step_a(1'b0, 1'b0, 1'b0);
    chk("a_resync_fs_drop", int'(a.frame_start), 0);

    // Reset with CE during the sync phase.
    adv_a_to(640);
    chk("a_640_vsync", int'(a.vsync), 1);
    step_a(1'b1, 1'b0, 1'b1);
    chk("a_rst_cnt", int'(a.cnt), 0);
    chk("a_rst_vsync", int'(a.vsync), 0);
    chk("a_rst_fs", int'(a.frame_start), 0);

    // Hold on the last line, then wrap.
    adv_a_to(665);
    for (int i = 0; i < 100; i++) step_a(1'b0, 1'b0, 1'b0);
    chk("a_hold_last_line", int'(a.last_line), 1);
    chk("a_hold_cnt", int'(a.cnt), 665);
    step_a(1'b1, 1'b0, 1'b0);
    chk("a_wrap_cnt", int'(a.cnt), 0);
    chk("a_wrap_fs", int'(a.frame_start), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
